// File: rtl/sd_pkg.sv
// Shared SD-interface definitions: frame geometry, CRC7 polynomial,
// generator FSM states and commonly used command indices.
package sd_pkg;

    localparam int          FRAME_LEN = 48;
    localparam logic [6:0]  CRC7_POLY = 7'h09;

    localparam logic [5:0]  CMD0   = 6'd0;
    localparam logic [5:0]  CMD8   = 6'd8;
    localparam logic [5:0]  CMD55  = 6'd55;
    localparam logic [5:0]  ACMD41 = 6'd41;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        FRAME,
        DONE
    } gen_state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one data bit per enabled cycle, MSB first.
// Shared by the command generator and the response checker.
module sd_crc7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] crc
);
    import sd_pkg::*;

    logic feedback;

    assign feedback = crc[6] ^ data_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{feedback}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/cmd_generator.sv
// SD command generator: idle-high preamble followed by one 48-bit command
// frame shifted out MSB first on pin_out, with a done pulse at the end.
module cmd_generator #(
    parameter logic [5:0]  CMD_INDEX   = 6'd0,
    parameter logic [31:0] CMD_ARG     = 32'h0000_0000,
    parameter int          INIT_CLOCKS = 80
) (
    input  logic clk,
    input  logic rst_n,
    input  logic state,
    output logic pin_out,
    output logic busy,
    output logic done
);
    import sd_pkg::*;

    localparam logic [39:0] HEADER    = {2'b01, CMD_INDEX, CMD_ARG};
    localparam logic [9:0]  PRE_LOAD  = 10'(INIT_CLOCKS);
    localparam logic [5:0]  LAST_BIT  = 6'(FRAME_LEN - 1);
    localparam logic [5:0]  CRC_START = 6'd7;

    gen_state_t  fsm;
    logic        armed;
    logic [9:0]  pre_count;
    logic [5:0]  bit_idx;
    logic [39:0] hdr_shift;
    logic        crc_clear;
    logic        crc_en;
    logic [6:0]  crc;

    // The CRC absorbs each header bit on the same edge that puts it on pin_out,
    // so it is complete exactly when bit 7 (CRC MSB) is due.
    assign crc_clear = (fsm != FRAME);
    assign crc_en    = (fsm == FRAME) && (bit_idx > CRC_START);

    sd_crc7 u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (crc_clear),
        .enable   (crc_en),
        .data_bit (hdr_shift[39]),
        .crc      (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            armed     <= 1'b1;
            pre_count <= '0;
            bit_idx   <= LAST_BIT;
            hdr_shift <= HEADER;
            pin_out   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    pin_out   <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pre_count <= PRE_LOAD;
                    bit_idx   <= LAST_BIT;
                    hdr_shift <= HEADER;
                    if (!state) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed <= 1'b0;
                        fsm   <= (INIT_CLOCKS == 0) ? FRAME : PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    pin_out   <= 1'b1;
                    busy      <= 1'b1;
                    pre_count <= pre_count - 10'd1;
                    if (pre_count == 10'd1) begin
                        fsm <= FRAME;
                    end
                end
                FRAME: begin
                    busy    <= 1'b1;
                    bit_idx <= bit_idx - 6'd1;
                    if (bit_idx > CRC_START) begin
                        pin_out   <= hdr_shift[39];
                        hdr_shift <= {hdr_shift[38:0], 1'b0};
                    end else if (bit_idx != 6'd0) begin
                        pin_out <= crc[bit_idx[2:0] - 3'd1];
                    end else begin
                        pin_out <= 1'b1;
                        fsm     <= DONE;
                    end
                end
                DONE: begin
                    pin_out <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (!state) begin
                        armed <= 1'b1;
                    end
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_generator.sv
// Scoreboard bench for cmd_generator: three parameterisations share one
// stimulus stream; a transaction-level model predicts every output cycle.
module tb_cmd_generator;
    import sd_pkg::*;

    localparam int NUM_DUT = 3;

    typedef struct packed {
        int         inst;
        logic [2:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    logic state;
    logic [NUM_DUT-1:0] pin_v;
    logic [NUM_DUT-1:0] busy_v;
    logic [NUM_DUT-1:0] done_v;

    exp_t        sb[$];
    int          check_count;
    int          pass_count;
    int          model_pos   [NUM_DUT];
    bit          model_armed [NUM_DUT];
    int          ic          [NUM_DUT];
    logic [47:0] frm         [NUM_DUT];
    logic [47:0] cap         [NUM_DUT];
    int          bcnt        [NUM_DUT];

    cmd_generator #(.CMD_INDEX(CMD0), .CMD_ARG(32'h0000_0000), .INIT_CLOCKS(80)) dut0 (
        .clk(clk), .rst_n(rst_n), .state(state),
        .pin_out(pin_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    cmd_generator #(.CMD_INDEX(CMD8), .CMD_ARG(32'h0000_01AA), .INIT_CLOCKS(80)) dut1 (
        .clk(clk), .rst_n(rst_n), .state(state),
        .pin_out(pin_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    cmd_generator #(.CMD_INDEX(CMD55), .CMD_ARG(32'h0000_0000), .INIT_CLOCKS(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .state(state),
        .pin_out(pin_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CRC7 as the remainder of polynomial long division of header * x^7.
    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] hdr;
        logic [46:0] rem;
        hdr = {2'b01, idx, arg};
        rem = {hdr, 7'd0};
        for (int k = 46; k >= 7; k--) begin
            if (rem[k]) rem[k -: 8] = rem[k -: 8] ^ 8'b1000_1001;
        end
        return {hdr, rem[6:0], 1'b1};
    endfunction

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected {pin_out, busy, done} for position p within a transaction.
    function automatic logic [2:0] waveform(input int i, input int p);
        if (p <= ic[i])      return 3'b110;
        if (p <= ic[i] + 48) return {frm[i][48 + ic[i] - p], 2'b10};
        return 3'b101;
    endfunction

    function automatic void model_step(input int i, input logic st, input logic rn);
        exp_t e;
        e.inst = i;
        if (!rn) begin
            model_pos[i]   = 0;
            model_armed[i] = 1'b1;
            e.val          = 3'b100;
        end else if (model_pos[i] == 0) begin
            e.val = 3'b100;
            if (st && model_armed[i]) begin
                model_armed[i] = 1'b0;
                model_pos[i]   = 1;
            end else if (!st) begin
                model_armed[i] = 1'b1;
            end
        end else begin
            e.val = waveform(i, model_pos[i]);
            if (model_pos[i] == ic[i] + 49) begin
                if (!st) model_armed[i] = 1'b1;
                model_pos[i] = 0;
            end else begin
                model_pos[i]++;
            end
        end
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(input logic st, input logic rn);
        @(negedge clk);
        state = st;
        rst_n = rn;
        for (int i = 0; i < NUM_DUT; i++) model_step(i, st, rn);
        @(posedge clk);
    endtask

    task automatic hold(input logic st, input int n);
        for (int k = 0; k < n; k++) applyStimulus(st, 1'b1);
    endtask

    // Monitor: pops one prediction per DUT each cycle and also checks each
    // completed frame as a whole against its expected 48-bit image.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() >= NUM_DUT) begin
                for (int k = 0; k < NUM_DUT; k++) begin
                    e = sb.pop_front();
                    checkOutput($sformatf("dut%0d_out", e.inst),
                                {45'd0, pin_v[e.inst], busy_v[e.inst], done_v[e.inst]},
                                {45'd0, e.val});
                end
                for (int i = 0; i < NUM_DUT; i++) begin
                    if (!rst_n) begin
                        bcnt[i] = 0;
                    end else begin
                        if (busy_v[i] === 1'b1) begin
                            cap[i] = {cap[i][46:0], pin_v[i]};
                            bcnt[i]++;
                        end
                        if (done_v[i] === 1'b1) begin
                            checkOutput($sformatf("dut%0d_frame", i), cap[i], frm[i]);
                            checkOutput($sformatf("dut%0d_busy_len", i), 48'(bcnt[i]), 48'(ic[i] + 48));
                            bcnt[i] = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic st;
        logic rn;
        check_count = 0;
        pass_count  = 0;
        ic  = '{80, 80, 0};
        frm[0] = 48'h40_0000_0000_95;
        frm[1] = 48'h48_0000_01AA_87;
        frm[2] = build_frame(CMD55, 32'h0000_0000);
        for (int i = 0; i < NUM_DUT; i++) begin
            model_pos[i]   = 0;
            model_armed[i] = 1'b1;
            cap[i]         = '0;
            bcnt[i]        = 0;
        end
        state = 1'b0;
        rst_n = 1'b0;

        $display("[TB] reset and single command with state held high");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
        hold(1'b1, 200);

        $display("[TB] re-arm after one low cycle");
        hold(1'b0, 1);
        hold(1'b1, 140);

        $display("[TB] reset during preamble, then full resend");
        hold(1'b0, 5);
        hold(1'b1, 40);
        applyStimulus(1'b1, 1'b0);
        hold(1'b0, 2);
        hold(1'b1, 140);

        $display("[TB] state dropped during frame");
        hold(1'b0, 3);
        hold(1'b1, 108);
        hold(1'b0, 60);

        $display("[TB] randomized state and reset");
        st = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) st = ~st;
            rn = ($urandom_range(0, 799) != 0);
            applyStimulus(st, rn);
        end
        hold(1'b0, 140);

        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 48'(sb.size()), 48'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cmd_generator.md
Name: cmd_generator

Overview:
- Serial SD-card command generator for the SD interface.
- When `state` requests a transmission, it emits a power-up preamble of idle-high clocks, then one 48-bit SD command frame, bit-serially on `pin_out`.
- The frame is: start, transmission bit, index, argument, CRC7, end bit.
- Sits between the SD controller FSM and the card's CMD/MOSI pin. One bit per `clk` cycle.

Parameters:
- CMD_INDEX, 6'd0, command index placed in frame bits [45:40].
- CMD_ARG, 32'h0000_0000, argument placed in frame bits [39:8].
- INIT_CLOCKS, 80, number of idle-high cycles sent before the frame. Legal range 0..1023.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- state  input  1  send request, level-sensitive with an arming rule.
- pin_out  output  1  serial command line; idles high.
- busy  output  1  high while preamble or frame is in progress.
- done  output  1  one-cycle pulse after the frame's end bit.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: pin_out=1, busy=0, done=0, FSM=IDLE, armed=1.
- All outputs are registered.
- FSM states: IDLE, PREAMBLE, FRAME, DONE.
- IDLE:
  - pin_out=1.
  - If state=1 and armed=1: go to PREAMBLE, clear armed, load the bit counter.
  - If INIT_CLOCKS=0: go directly to FRAME.
- Arming:
  - armed is set whenever state=0 is sampled outside PREAMBLE/FRAME.
  - Holding state=1 permanently therefore yields exactly one command.
  - A new command requires state to return low for at least one cycle.
- PREAMBLE:
  - pin_out=1 for exactly INIT_CLOCKS cycles, busy=1.
  - Then go to FRAME.
- FRAME:
  - 48 bits, MSB first, one per cycle, busy=1.
  - Bit 47 = 0 (start); bit 46 = 1 (host transmission).
  - Bits 45:40 = CMD_INDEX; bits 39:8 = CMD_ARG.
  - Bits 7:1 = CRC7; bit 0 = 1 (end).
- CRC7:
  - Polynomial x^7+x^3+1, register initialised to 0.
  - Computed over frame bits 47:8, MSB first.
  - Either computed serially during transmission or precomputed; the result must be identical.
- DONE:
  - One cycle with done=1, busy=0, pin_out=1.
  - Then IDLE.
- Latency:
  - state sampled high at edge N → first preamble bit on pin_out after edge N+1.
  - End bit is on pin_out for the cycle following edge N+INIT_CLOCKS+48.
  - done=1 after the next edge.
- state dropping low during PREAMBLE/FRAME is ignored; the frame completes.
- Reset asserted mid-operation aborts immediately at that edge; the block returns to reset values with pin_out=1.
- No X on pin_out at any time after the first reset edge.

Decomposition:
- Shared package sd_pkg holds:
  - FRAME_LEN=48.
  - CRC7_POLY=7'h09.
  - The FSM state enum (IDLE, PREAMBLE, FRAME, DONE).
  - Common command index constants (CMD0=0, CMD8=8, CMD55=55, ACMD41=41).
- One sub-module, sd_crc7:
  - Serial CRC7 with clear, enable and data-bit inputs, and a 7-bit crc output.
  - Reusable for the response checker.

Test Plan:
- Reset then hold state=1 with defaults (CMD0, arg 0, INIT_CLOCKS=80):
  - 80 ones, then frame bytes 0x40 00 00 00 00 0x95 MSB first.
  - One done pulse, then pin_out=1 forever.
  - No second frame while state stays 1.
- CMD_INDEX=8, CMD_ARG=32'h0000_01AA: frame bytes 0x48 00 00 01 AA 0x87.
- Re-arm: state 1→0 (1 cycle)→1 after done → a second identical preamble+frame.
- Drop state to 0 at frame bit 20 → frame still completes with correct CRC; busy high throughout.
- Assert rst_n=0 at preamble cycle 40 → pin_out=1, busy=0 at next edge; a new send after release starts a full 80-cycle preamble.
- INIT_CLOCKS=0:
  - Start bit 0 appears on pin_out one cycle after state is sampled high.
  - busy is high for exactly 48 cycles.
